// File: rtl/sme_pkg.sv
// rtl/sme_pkg.sv - shared types and constants for the SME feeder
package sme_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_STR,
        SEND_PAT,
        GAP,
        WAIT,
        DONE
    } sme_state_t;

    localparam logic [7:0] CH_DOT   = 8'h2e;
    localparam logic [7:0] CH_STAR  = 8'h2a;
    localparam logic [7:0] CH_HEAD  = 8'h5e;
    localparam logic [7:0] CH_TAIL  = 8'h24;
    localparam logic [7:0] CH_SPACE = 8'h20;

    localparam int SIDX_W = 6;
    localparam int PIDX_W = 4;

    // Characters the engine interprets as pattern operators rather than literals
    function automatic logic is_meta(input logic [7:0] ch);
        return (ch == CH_DOT) || (ch == CH_STAR) || (ch == CH_HEAD) ||
               (ch == CH_TAIL) || (ch == CH_SPACE);
    endfunction

endpackage

// File: rtl/sme_feeder_if.sv
// rtl/sme_feeder_if.sv - character bus and result strobe between feeder and SME engine
interface sme_feeder_if;
    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic       valid;
    logic       match;
    logic [4:0] match_index;

    modport master (
        output chardata, isstring, ispattern,
        input  valid, match, match_index
    );

    modport slave (
        input  chardata, isstring, ispattern,
        output valid, match, match_index
    );
endinterface

// File: rtl/sme_char_buf.sv
// rtl/sme_char_buf.sv - append-only character buffer with length counter
module sme_char_buf #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             clr,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [7:0]       rd_data,
    output logic [IDX_W-1:0] len,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0] mem [DEPTH];

    assign full = (len == IDX_W'(DEPTH));

    // Reads past the current length return 0 so stale contents never leak out
    assign rd_data = (rd_idx < len) ? mem[rd_idx[AW-1:0]] : 8'h00;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len <= '0;
        end else if (clr) begin
            len <= '0;
        end else if (wr_en && !full) begin
            len <= len + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !full && !clr) begin
            mem[len[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/sme_feeder.sv
// rtl/sme_feeder.sv - serialises string/pattern jobs onto the SME bus and captures the result
module sme_feeder
    import sme_pkg::*;
#(
    parameter int SLEN_MAX = 32,
    parameter int PLEN_MAX = 8,
    parameter int TIMEOUT  = 63
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic               wr_sel,
    input  logic [7:0]         wr_data,
    input  logic               start,
    input  logic               send_str,
    output logic               busy,
    sme_feeder_if.master       eng,
    output logic               res_valid,
    output logic               res_match,
    output logic [4:0]         res_index,
    output logic               err_ovf,
    output logic               err_timeout
);
    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    sme_state_t          state;
    logic [SIDX_W-1:0]   idx;
    logic [TCNT_W-1:0]   tcnt;

    logic [SIDX_W-1:0]   slen, s_rd_idx;
    logic [PIDX_W-1:0]   plen, p_rd_idx;
    logic [7:0]          s_rd, p_rd;
    logic                sfull, pfull;
    logic                in_idle, ovf_hit, start_ok;

    assign in_idle  = (state == IDLE);
    assign ovf_hit  = in_idle && wr_en && (wr_sel ? pfull : sfull);
    assign start_ok = in_idle && start && (plen != '0) && (!send_str || (slen != '0));

    // Index 0 is presented outside the send states so the first char is ready at launch
    assign s_rd_idx = (state == SEND_STR) ? idx : '0;
    assign p_rd_idx = (state == SEND_PAT) ? idx[PIDX_W-1:0] : '0;

    sme_char_buf #(.DEPTH(SLEN_MAX), .IDX_W(SIDX_W)) u_str_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (in_idle && wr_en && !wr_sel),
        .wr_data (wr_data),
        .clr     (1'b0),
        .rd_idx  (s_rd_idx),
        .rd_data (s_rd),
        .len     (slen),
        .full    (sfull)
    );

    sme_char_buf #(.DEPTH(PLEN_MAX), .IDX_W(PIDX_W)) u_pat_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (in_idle && wr_en && wr_sel),
        .wr_data (wr_data),
        .clr     (state == DONE),
        .rd_idx  (p_rd_idx),
        .rd_data (p_rd),
        .len     (plen),
        .full    (pfull)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            idx           <= '0;
            tcnt          <= '0;
            busy          <= 1'b0;
            eng.chardata  <= 8'h00;
            eng.isstring  <= 1'b0;
            eng.ispattern <= 1'b0;
            res_valid     <= 1'b0;
            res_match     <= 1'b0;
            res_index     <= 5'd0;
            err_ovf       <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        err_ovf     <= ovf_hit;
                        err_timeout <= 1'b0;
                        busy        <= 1'b1;
                        idx         <= SIDX_W'(1);
                        if (send_str) begin
                            state        <= SEND_STR;
                            eng.isstring <= 1'b1;
                            eng.chardata <= s_rd;
                        end else begin
                            state         <= SEND_PAT;
                            eng.ispattern <= 1'b1;
                            eng.chardata  <= p_rd;
                        end
                    end else if (ovf_hit) begin
                        err_ovf <= 1'b1;
                    end
                end

                SEND_STR: begin
                    if (idx == slen) begin
                        state         <= SEND_PAT;
                        eng.isstring  <= 1'b0;
                        eng.ispattern <= 1'b1;
                        eng.chardata  <= p_rd;
                        idx           <= SIDX_W'(1);
                    end else begin
                        eng.chardata <= s_rd;
                        idx          <= idx + 1'b1;
                    end
                end

                SEND_PAT: begin
                    if (idx == SIDX_W'(plen)) begin
                        state         <= GAP;
                        eng.ispattern <= 1'b0;
                        eng.chardata  <= 8'h00;
                    end else begin
                        eng.chardata <= p_rd;
                        idx          <= idx + 1'b1;
                    end
                end

                GAP: begin
                    state <= WAIT;
                    tcnt  <= TCNT_W'(1);
                end

                // tcnt holds the 1-based number of the current WAIT cycle
                WAIT: begin
                    if (eng.valid) begin
                        res_match <= eng.match;
                        res_index <= eng.match_index;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else if (tcnt == TCNT_W'(TIMEOUT)) begin
                        err_timeout <= 1'b1;
                        res_match   <= 1'b0;
                        res_index   <= 5'd0;
                        res_valid   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sme_feeder.sv
// tb/tb_sme_feeder.sv - directed self-checking bench for sme_feeder
module tb_sme_feeder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic       wr_sel = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       start = 1'b0;
    logic       send_str = 1'b0;
    logic       busy, res_valid, res_match, err_ovf, err_timeout;
    logic [4:0] res_index;

    always #5 clk = ~clk;

    sme_feeder_if bus ();

    sme_feeder #(.SLEN_MAX(32), .PLEN_MAX(8), .TIMEOUT(63)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_data     (wr_data),
        .start       (start),
        .send_str    (send_str),
        .busy        (busy),
        .eng         (bus.master),
        .res_valid   (res_valid),
        .res_match   (res_match),
        .res_index   (res_index),
        .err_ovf     (err_ovf),
        .err_timeout (err_timeout)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    logic [7:0] sq[$];
    logic [7:0] pq[$];
    int         res_cnt, res_n, first_act, first_busy, gap_ok, done_ok;
    logic       got_m, ovf_in_job, tmo_at_res;
    logic [4:0] got_i;

    function automatic logic [31:0] pack(input logic [7:0] q[$]);
        logic [31:0] v = '0;
        foreach (q[i]) v = {v[23:0], q[i]};
        return v;
    endfunction

    task automatic wr(input logic sel, input logic [7:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic wr_str(input logic sel, input string s);
        for (int i = 0; i < s.len(); i++) wr(sel, s[i]);
    endtask

    // n counts negedges since the GAP cycle; valid raised at n is seen by WAIT cycle n
    task automatic run_job(input logic ss, input int vdelay, input logic m,
                           input logic [4:0] mi, input logic wr_busy);
        int   n;
        logic prev_pat, gap;
        sq.delete(); pq.delete();
        res_cnt = 0; res_n = -1; gap_ok = 0; done_ok = 0;
        first_act = 0; first_busy = 0; ovf_in_job = 1'b1; tmo_at_res = 1'bx;
        got_m = 1'bx; got_i = 'x;
        start = 1'b1; send_str = ss;
        @(posedge clk); #1;
        start = 1'b0; send_str = 1'b0;
        prev_pat = 1'b0; gap = 1'b0; n = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            bus.valid = 1'b0;
            wr_en = 1'b0;
            if (cyc == 0) begin
                first_act  = int'(bus.isstring | bus.ispattern);
                first_busy = int'(busy);
                ovf_in_job = err_ovf;
            end
            if (bus.isstring)  sq.push_back(bus.chardata);
            if (bus.ispattern) pq.push_back(bus.chardata);
            if (gap) n++;
            if (prev_pat && !bus.ispattern && !gap) begin
                gap = 1'b1;
                n = 0;
                gap_ok = int'(bus.chardata == 8'h00 && !bus.isstring);
            end
            prev_pat = bus.ispattern;
            if (res_valid) begin
                res_cnt++; res_n = n;
                got_m = res_match; got_i = res_index; tmo_at_res = err_timeout;
            end
            if (cyc > 0 && !busy) begin
                done_ok = 1;
                break;
            end
            if (gap && vdelay >= 0 && n == vdelay) begin
                bus.valid = 1'b1; bus.match = m; bus.match_index = mi;
            end
            if (wr_busy) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_data = 8'h7a;
            end
        end
        bus.valid = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic try_ignored(input logic ss, output int act);
        act = 0;
        start = 1'b1; send_str = ss;
        @(posedge clk); #1;
        start = 1'b0; send_str = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            act |= int'(busy | bus.isstring | bus.ispattern | (bus.chardata != 8'h00));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int act;
        bus.valid = 1'b0; bus.match = 1'b0; bus.match_index = 5'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {busy, bus.isstring, bus.ispattern, bus.chardata, res_valid,
                            res_match, res_index, err_ovf, err_timeout}, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", {busy, bus.isstring, bus.ispattern, bus.chardata, res_valid}, 0);

        // Full job: string "abcd", pattern "bc"
        wr_str(1'b0, "abcd");
        wr_str(1'b1, "bc");
        run_job(1'b1, 3, 1'b1, 5'd1, 1'b0);
        chk("t1_done", done_ok, 1);
        chk("t1_first_latency", first_act, 1);
        chk("t1_busy", first_busy, 1);
        chk("t1_str_len", sq.size(), 4);
        chk("t1_str_data", pack(sq), 32'h61626364);
        chk("t1_pat_len", pq.size(), 2);
        chk("t1_pat_data", pack(pq), 32'h00006263);
        chk("t1_gap", gap_ok, 1);
        chk("t1_res_cnt", res_cnt, 1);
        chk("t1_res", {got_m, got_i}, {1'b1, 5'd1});
        chk("t1_res_lat", res_n, 4);
        chk("t1_hold", {res_match, res_index}, {1'b1, 5'd1});

        // Pattern-only job reusing the engine's string
        wr_str(1'b1, "d");
        run_job(1'b0, 2, 1'b1, 5'd3, 1'b0);
        chk("t2_done", done_ok, 1);
        chk("t2_no_str", sq.size(), 0);
        chk("t2_pat_len", pq.size(), 1);
        chk("t2_pat_data", pack(pq), 32'h64);
        chk("t2_res", {got_m, got_i}, {1'b1, 5'd3});
        chk("t2_res_lat", res_n, 3);

        // Pattern buffer overflow
        wr_str(1'b1, "ABCDEFGH");
        chk("t3_full_no_ovf", err_ovf, 0);
        wr(1'b1, 8'h5a);
        chk("t3_ovf_set", err_ovf, 1);
        run_job(1'b1, 1, 1'b1, 5'd5, 1'b0);
        chk("t3_ovf_cleared", ovf_in_job, 0);
        chk("t3_str_retained", pack(sq), 32'h61626364);
        chk("t3_pat_len", pq.size(), 8);
        chk("t3_pat_ends", {pq[0], pq[7]}, 16'h4148);
        chk("t3_res", {got_m, got_i}, {1'b1, 5'd5});

        // Engine never answers
        wr_str(1'b1, "x");
        run_job(1'b0, -1, 1'b1, 5'd9, 1'b0);
        chk("t4_done", done_ok, 1);
        chk("t4_res_cnt", res_cnt, 1);
        chk("t4_tmo_lat", res_n, 64);
        chk("t4_res_zero", {got_m, got_i}, 6'd0);
        chk("t4_tmo_flag", tmo_at_res, 1);
        chk("t4_tmo_sticky", err_timeout, 1);

        // valid on the expiry cycle wins
        wr_str(1'b1, "y");
        run_job(1'b0, 63, 1'b1, 5'd7, 1'b0);
        chk("t4b_res", {got_m, got_i}, {1'b1, 5'd7});
        chk("t4b_no_tmo", tmo_at_res, 0);
        chk("t4b_lat", res_n, 64);

        // plen cleared by DONE, so start is ignored
        try_ignored(1'b0, act);
        chk("t5_plen0_ignored", act, 0);

        // Asynchronous reset in the middle of SEND_STR
        wr_str(1'b1, "p");
        start = 1'b1; send_str = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; send_str = 1'b0;
        @(negedge clk);
        chk("t6_in_send", {busy, bus.isstring}, 2'b11);
        #2 reset = 1'b0;
        #1;
        chk("t6_async_drop", {busy, bus.isstring, bus.ispattern, bus.chardata}, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        try_ignored(1'b0, act);
        chk("t6_plen_cleared", act, 0);
        wr_str(1'b1, "p");
        try_ignored(1'b1, act);
        chk("t6_slen_cleared", act, 0);

        // Writes during a job are ignored
        wr_str(1'b0, "mn");
        run_job(1'b1, 2, 1'b0, 5'd2, 1'b1);
        chk("t5b_str", pack(sq), 32'h6d6e);
        chk("t5b_pat", pack(pq), 32'h70);
        wr_str(1'b1, "k");
        run_job(1'b1, 2, 1'b0, 5'd2, 1'b0);
        chk("t5b_str_unchanged", sq.size(), 2);
        chk("t5b_pat_unchanged", pack(pq), 32'h6b);
        chk("t5b_res", {got_m, got_i}, {1'b0, 5'd2});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
